// File: rtl/time_bar_renderer_pkg.sv
// Shared types and sprite geometry for the HUD time bar.
// Imported by the countdown and the renderer top.
package frogger_hud_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } hud_state_t;

  localparam int TIME_SPR_W = 34;
  localparam int TIME_SPR_H = 8;
  localparam logic [3:0] TRANSPARENT = 4'h0;

endpackage

// File: rtl/time_bar_renderer_if.sv
// Sprite ROM port: address out, registered data back.
// The renderer is master, the ROM is slave.
interface time_bar_renderer_if;

  logic [8:0] rom_addr;
  logic [3:0] rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );

endinterface

// File: rtl/time_bar_renderer_countdown.sv
// Per-life countdown FSM: frame prescaler, time_left,
// and a one-cycle expired pulse.
module hud_countdown
  import frogger_hud_pkg::*;
#(
  parameter int TIME_MAX        = 60,
  parameter int FRAMES_PER_UNIT = 30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       start,
  input  logic       pause,
  output logic [6:0] time_left,
  output logic       expired
);

  localparam int FW =
    (FRAMES_PER_UNIT > 1) ? $clog2(FRAMES_PER_UNIT) : 1;
  localparam logic [FW-1:0] FC_LAST = FW'(FRAMES_PER_UNIT - 1);
  localparam logic [6:0] TL_MAX = 7'(TIME_MAX);

  hud_state_t    state_q, state_d;
  logic [FW-1:0] fc_q, fc_d;
  logic [6:0]    tl_q, tl_d;
  logic          exp_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      fc_q    <= '0;
      tl_q    <= TL_MAX;
      expired <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      tl_q    <= tl_d;
      expired <= exp_d;
    end
  end

  // start overrides everything, including pause and frame_start
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    tl_d    = tl_q;
    exp_d   = 1'b0;
    if (start) begin
      state_d = RUN;
      fc_d    = '0;
      tl_d    = TL_MAX;
    end else begin
      unique case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (frame_start) begin
            if (fc_q == FC_LAST) begin
              fc_d = '0;
              tl_d = tl_q - 7'd1;
              if (tl_q == 7'd1) begin
                state_d = EXPIRED;
                exp_d   = 1'b1;
              end
            end else begin
              fc_d = fc_q + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!pause) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  assign time_left = tl_q;

endmodule

// File: rtl/time_bar_renderer.sv
// HUD time bar: TIME label sprite addressing, shrinking
// bar hit test and a 2-stage pixel pipeline.
module time_bar_renderer
  import frogger_hud_pkg::*;
#(
  parameter int         LABEL_X         = 8,
  parameter int         LABEL_Y         = 464,
  parameter int         BAR_X           = 48,
  parameter int         BAR_Y           = 466,
  parameter int         BAR_H           = 4,
  parameter int         BAR_SCALE       = 4,
  parameter int         TIME_MAX        = 60,
  parameter int         FRAMES_PER_UNIT = 30,
  parameter int         WARN_LEVEL      = 10,
  parameter logic [3:0] BAR_COLOR       = 4'hA,
  parameter logic [3:0] BAR_WARN_COLOR  = 4'h4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_start,
  input  logic                 start,
  input  logic                 pause,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  time_bar_renderer_if.master  rom,
  output logic [3:0]           pixel_idx,
  output logic                 pixel_on,
  output logic [6:0]           time_left,
  output logic                 expired
);

  localparam logic [9:0] LX     = 10'(LABEL_X);
  localparam logic [9:0] LX_END = 10'(LABEL_X + TIME_SPR_W);
  localparam logic [9:0] LY     = 10'(LABEL_Y);
  localparam logic [9:0] LY_END = 10'(LABEL_Y + TIME_SPR_H);
  localparam logic [9:0] BX     = 10'(BAR_X);
  localparam logic [9:0] BY     = 10'(BAR_Y);
  localparam logic [9:0] BY_END = 10'(BAR_Y + BAR_H);
  localparam logic [9:0] SCALE  = 10'(BAR_SCALE);
  localparam logic [8:0] SPR_W  = 9'(TIME_SPR_W);
  localparam logic [6:0] WARN   = 7'(WARN_LEVEL);

  logic       label_hit, bar_hit, warn;
  logic [8:0] lx_off;
  logic [2:0] ly_off;
  logic [9:0] bar_end;
  logic       label_q, bar_q, warn_q;

  hud_countdown #(
    .TIME_MAX        (TIME_MAX),
    .FRAMES_PER_UNIT (FRAMES_PER_UNIT)
  ) u_countdown (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .start       (start),
    .pause       (pause),
    .time_left   (time_left),
    .expired     (expired)
  );

  assign label_hit = DrawX >= LX && DrawX < LX_END &&
                     DrawY >= LY && DrawY < LY_END;
  assign lx_off    = 9'(DrawX - LX);
  assign ly_off    = 3'(DrawY - LY);

  assign rom.rom_addr = label_hit ?
    {6'd0, ly_off} * SPR_W + lx_off : '0;

  // time_left=0 collapses bar_end onto BX, so the bar is empty
  assign bar_end = BX + {3'd0, time_left} * SCALE;
  assign bar_hit = DrawY >= BY && DrawY < BY_END &&
                   DrawX >= BX && DrawX < bar_end;
  assign warn    = time_left <= WARN;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      label_q   <= 1'b0;
      bar_q     <= 1'b0;
      warn_q    <= 1'b0;
      pixel_idx <= '0;
      pixel_on  <= 1'b0;
    end else begin
      label_q <= label_hit;
      bar_q   <= bar_hit;
      warn_q  <= warn;
      priority case (1'b1)
        label_q: begin
          pixel_idx <= rom.rom_data;
          pixel_on  <= rom.rom_data != TRANSPARENT;
        end
        bar_q: begin
          pixel_idx <= warn_q ? BAR_WARN_COLOR : BAR_COLOR;
          pixel_on  <= 1'b1;
        end
        default: begin
          pixel_idx <= '0;
          pixel_on  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_bar_renderer.sv
// Randomized bench for time_bar_renderer against a
// spec-level countdown and pixel reference model.
module tb_time_bar_renderer;
  import frogger_hud_pkg::*;

  localparam int TMAX  = 60;
  localparam int FPU   = 30;
  localparam int TOTAL = TMAX * FPU;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [3:0] pixel_idx;
  logic       pixel_on;
  logic [6:0] time_left;
  logic       expired;

  time_bar_renderer_if rom_if ();

  time_bar_renderer dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .start       (start),
    .pause       (pause),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom         (rom_if),
    .pixel_idx   (pixel_idx),
    .pixel_on    (pixel_on),
    .time_left   (time_left),
    .expired     (expired)
  );

  always #5 Clk = ~Clk;

  logic [3:0] rom_mem [0:511];
  always @(posedge Clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

  int exp_cycles = 0;
  always @(negedge Clk) if (expired === 1'b1) exp_cycles++;

  int passed = 0;
  int total  = 0;

  int m_n   = 0;
  bit m_run = 0;

  function automatic int exp_tl(int n);
    return (n / FPU >= TMAX) ? 0 : TMAX - n / FPU;
  endfunction

  // {on, idx} from the geometry rules
  function automatic logic [4:0] exp_pix(int x, int y, int tl);
    logic [3:0] d;
    if (x >= 8 && x < 42 && y >= 464 && y < 472) begin
      d = rom_mem[(y - 464) * 34 + (x - 8)];
      return {d != 4'h0, d};
    end
    if (y >= 466 && y < 470 && x >= 48 && x < 48 + tl * 4)
      return {1'b1, (tl <= 10) ? 4'h4 : 4'hA};
    return 5'd0;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse(output logic ex);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (m_run && !pause && m_n < TOTAL) m_n++;
    ex = expired;
    repeat ($urandom_range(0, 1)) tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_n   = 0;
    m_run = 1;
  endtask

  task automatic pulses(int n);
    logic ex;
    for (int i = 0; i < n; i++) pulse(ex);
  endtask

  task automatic test_reset();
    logic [4:0] e;
    Reset_n = 1'b0;
    DrawX = 10'd10;
    DrawY = 10'd465;
    repeat (3) tick();
    total++;
    if (time_left !== 7'd60 || expired !== 1'b0) begin
      $display("FAIL reset_cnt: time_left=%0d expired=%b want 60/0",
               time_left, expired);
    end else passed++;
    total++;
    if (pixel_on !== 1'b0 || pixel_idx !== 4'h0) begin
      $display("FAIL reset_pix: on=%b idx=%h want 0/0",
               pixel_on, pixel_idx);
    end else passed++;
    Reset_n = 1'b1;
    tick();
    pulses(40);
    total++;
    if (time_left !== 7'd60) begin
      $display("FAIL idle_hold: time_left=%0d want 60", time_left);
    end else passed++;
    // async clear mid-frame, outputs stay 0 until S2 refills
    DrawX = 10'd20;
    DrawY = 10'd468;
    rom_mem[4 * 34 + 12] = 4'h7;
    e = exp_pix(20, 468, 60);
    tick();
    tick();
    total++;
    if ({pixel_on, pixel_idx} !== e) begin
      $display("FAIL pre_mid_reset: got=%h want=%h",
               {pixel_on, pixel_idx}, e);
    end else passed++;
    Reset_n = 1'b0;
    #2;
    total++;
    if (pixel_on !== 1'b0 || pixel_idx !== 4'h0) begin
      $display("FAIL mid_reset: on=%b idx=%h want 0/0",
               pixel_on, pixel_idx);
    end else passed++;
    tick();
    Reset_n = 1'b1;
    tick();
    total++;
    if (pixel_on !== 1'b0) begin
      $display("FAIL post_reset_s1: on=%b want 0", pixel_on);
    end else passed++;
    tick();
    total++;
    if ({pixel_on, pixel_idx} !== e) begin
      $display("FAIL post_reset_s2: got=%h want=%h",
               {pixel_on, pixel_idx}, e);
    end else passed++;
  endtask

  task automatic test_first_unit();
    int e0;
    e0 = exp_cycles;
    do_start();
    pulses(29);
    total++;
    if (time_left !== 7'd60) begin
      $display("FAIL unit_29: time_left=%0d want 60", time_left);
    end else passed++;
    pulses(1);
    total++;
    if (time_left !== 7'd59) begin
      $display("FAIL unit_30: time_left=%0d want 59", time_left);
    end else passed++;
    total++;
    if (exp_cycles != e0) begin
      $display("FAIL unit_noexp: expired cycles=%0d want 0",
               exp_cycles - e0);
    end else passed++;
  endtask

  task automatic test_expiry();
    int e0, bad;
    logic ex, hit;
    bad = 0;
    hit = 1'b0;
    e0  = exp_cycles;
    do_start();
    for (int i = 0; i < TOTAL; i++) begin
      pulse(ex);
      if (int'(time_left) != exp_tl(m_n)) bad++;
      if (m_n == TOTAL) hit = ex;
    end
    total++;
    if (bad != 0) begin
      $display("FAIL expiry_track: mismatches=%0d want 0", bad);
    end else passed++;
    total++;
    if (time_left !== 7'd0 || hit !== 1'b1) begin
      $display("FAIL expiry_end: time_left=%0d pulse=%b want 0/1",
               time_left, hit);
    end else passed++;
    pulses(50);
    total++;
    if (time_left !== 7'd0) begin
      $display("FAIL expiry_hold: time_left=%0d want 0", time_left);
    end else passed++;
    total++;
    if (exp_cycles - e0 != 1) begin
      $display("FAIL expiry_once: expired cycles=%0d want 1",
               exp_cycles - e0);
    end else passed++;
  endtask

  task automatic test_pause();
    int k, fc;
    k  = $urandom_range(31, 58);
    fc = k - FPU;
    do_start();
    pulses(k);
    pause = 1'b1;
    tick();
    pulses(100);
    total++;
    if (time_left !== 7'd59) begin
      $display("FAIL pause_frozen: time_left=%0d want 59", time_left);
    end else passed++;
    pause = 1'b0;
    tick();
    pulses(FPU - fc - 1);
    total++;
    if (time_left !== 7'd59) begin
      $display("FAIL resume_early: time_left=%0d want 59", time_left);
    end else passed++;
    pulses(1);
    total++;
    if (time_left !== 7'd58) begin
      $display("FAIL resume_unit: time_left=%0d want 58", time_left);
    end else passed++;
  endtask

  task automatic test_start_override();
    do_start();
    pulses(55 * FPU);
    total++;
    if (time_left !== 7'd5) begin
      $display("FAIL ovr_pre: time_left=%0d want 5", time_left);
    end else passed++;
    start = 1'b1;
    frame_start = 1'b1;
    pause = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    frame_start = 1'b0;
    pause = 1'b0;
    m_n = 0;
    tick();
    total++;
    if (time_left !== 7'd60) begin
      $display("FAIL ovr_reload: time_left=%0d want 60", time_left);
    end else passed++;
    pulses(29);
    total++;
    if (time_left !== 7'd60) begin
      $display("FAIL ovr_fc0: time_left=%0d want 60", time_left);
    end else passed++;
    pulses(1);
    total++;
    if (time_left !== 7'd59) begin
      $display("FAIL ovr_run: time_left=%0d want 59", time_left);
    end else passed++;
  endtask

  task automatic test_label();
    int x, y, a;
    logic [4:0] e;
    rom_mem[271] = 4'h0;
    DrawX = 10'd41;
    DrawY = 10'd471;
    #1;
    total++;
    if (rom_if.rom_addr !== 9'd271) begin
      $display("FAIL addr_corner: addr=%0d want 271", rom_if.rom_addr);
    end else passed++;
    tick();
    tick();
    total++;
    if (pixel_on !== 1'b0 || pixel_idx !== 4'h0) begin
      $display("FAIL label_transp: on=%b idx=%h want 0/0",
               pixel_on, pixel_idx);
    end else passed++;
    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(8, 41);
      y = $urandom_range(464, 471);
      a = (y - 464) * 34 + (x - 8);
      DrawX = 10'(x);
      DrawY = 10'(y);
      #1;
      total++;
      if (int'(rom_if.rom_addr) != a) begin
        $display("FAIL addr_in: x=%0d y=%0d addr=%0d want %0d",
                 x, y, rom_if.rom_addr, a);
      end else passed++;
      e = {rom_mem[a] != 4'h0, rom_mem[a]};
      tick();
      tick();
      total++;
      if ({pixel_on, pixel_idx} !== e) begin
        $display("FAIL label_pix: x=%0d y=%0d got=%h want=%h",
                 x, y, {pixel_on, pixel_idx}, e);
      end else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      DrawX = 10'($urandom_range(42, 639));
      DrawY = 10'($urandom_range(0, 463));
      #1;
      total++;
      if (rom_if.rom_addr !== 9'd0) begin
        $display("FAIL addr_out: addr=%0d want 0", rom_if.rom_addr);
      end else passed++;
    end
  endtask

  task automatic test_bar();
    int xs [6];
    int ys [6];
    logic [4:0] ws [6];
    do_start();
    xs = '{287, 288, 47, 200, 87, 100};
    ys = '{466, 469, 467, 470, 465, 468};
    ws = '{5'h1A, 5'h00, 5'h00, 5'h00, 5'h00, 5'h1A};
    for (int i = 0; i < 6; i++) begin
      DrawX = 10'(xs[i]);
      DrawY = 10'(ys[i]);
      tick();
      tick();
      total++;
      if ({pixel_on, pixel_idx} !== ws[i]) begin
        $display("FAIL bar_full: x=%0d y=%0d got=%h want=%h",
                 xs[i], ys[i], {pixel_on, pixel_idx}, ws[i]);
      end else passed++;
    end
    pulses(50 * FPU);
    DrawY = 10'd466;
    DrawX = 10'd87;
    tick();
    tick();
    total++;
    if (pixel_on !== 1'b1 || pixel_idx !== 4'h4) begin
      $display("FAIL bar_warn_87: on=%b idx=%h want 1/4",
               pixel_on, pixel_idx);
    end else passed++;
    DrawX = 10'd88;
    tick();
    tick();
    total++;
    if (pixel_on !== 1'b0 || pixel_idx !== 4'h0) begin
      $display("FAIL bar_warn_88: on=%b idx=%h want 0/0",
               pixel_on, pixel_idx);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    logic [4:0] q [$];
    logic [4:0] e;
    int x, y, bad;
    bad = 0;
    do_start();
    pulses($urandom_range(FPU * 40, TOTAL));
    for (int i = 0; i < 300; i++) begin
      x = $urandom_range(0, 299);
      y = $urandom_range(460, 475);
      DrawX = 10'(x);
      DrawY = 10'(y);
      q.push_back(exp_pix(x, y, exp_tl(m_n)));
      tick();
      if (i >= 1) begin
        e = q.pop_front();
        if ({pixel_on, pixel_idx} !== e) bad++;
      end
    end
    total++;
    if (bad != 0) begin
      $display("FAIL stream: mismatches=%0d want 0 (tl=%0d)",
               bad, exp_tl(m_n));
    end else passed++;
  endtask

  initial begin
    for (int i = 0; i < 512; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ?
        4'h0 : 4'($urandom_range(1, 15));
    test_reset();
    test_first_unit();
    test_expiry();
    test_pause();
    test_start_override();
    test_label();
    test_bar();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
